mapper_ss_seq: RTL and testbench

- Save-state sequencer for one mapper's snapshot bus (ss_act / ss_we / ss_addr / ss_dat / ss_rdat).
- On a host command it walks snapshot addresses FIRST..LAST in one of two modes:
  - save: streams each mapper register byte out to the host;
  - restore: writes host-supplied bytes back into the mapper.
- Sits between the host/menu-CPU save-state engine and the mapper map_out/ss_ctrl bundle.
- Mapper registers sample on falling m2, so every restore write is held until a falling m2 edge is seen.

---
 rtl/mapper_ss_seq.sv | 141 ++++++++++++++
 tb/tb_mapper_ss_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mapper_ss_seq.sv
// mapper_ss_seq: walks snapshot addresses FIRST..LAST, streaming mapper state out (save) or writing host bytes back in (restore).
module mapper_ss_seq #(
  parameter int FIRST  = 0,
  parameter int LAST   = 127,
  parameter int RD_LAT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       cmd_start,
  input  logic       cmd_restore,
  input  logic       cmd_abort,
  output logic       busy,
  output logic       done,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_dat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] up_dat,
  output logic       up_valid,
  input  logic       up_ready,
  input  logic [7:0] dn_dat,
  input  logic       dn_valid,
  output logic       dn_ready
);
  localparam logic [7:0] A_FIRST = 8'(FIRST);
  localparam logic [7:0] A_LAST  = 8'(LAST);
  localparam logic [2:0] LAT     = 3'(RD_LAT - 1);

  typedef enum logic [3:0] {IDLE, SETUP, RDWAIT, UP, DNWAIT, WEARM, WEHOLD, NEXT, FIN, ABORT} state_t;

  state_t     state, state_d;
  logic       restore, restore_d;
  logic [2:0] cnt, cnt_d;
  logic [7:0] addr_d, dat_d, up_dat_d;
  logic       busy_d, done_d, act_d, we_d, upv_d;
  logic [2:0] m2_sync;
  logic       m2_fall;

  // [0],[1] synchronize m2, [2] is the previous synchronized value for edge detection
  assign m2_fall  = m2_sync[2] & ~m2_sync[1];
  assign dn_ready = state == DNWAIT;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m2_sync  <= '0;
      state    <= IDLE;
      restore  <= 1'b0;
      cnt      <= '0;
      ss_addr  <= '0;
      ss_dat   <= '0;
      up_dat   <= '0;
      up_valid <= 1'b0;
      ss_we    <= 1'b0;
      ss_act   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      m2_sync  <= {m2_sync[1:0], m2};
      state    <= state_d;
      restore  <= restore_d;
      cnt      <= cnt_d;
      ss_addr  <= addr_d;
      ss_dat   <= dat_d;
      up_dat   <= up_dat_d;
      up_valid <= upv_d;
      ss_we    <= we_d;
      ss_act   <= act_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d   = state;
    restore_d = restore;
    cnt_d     = cnt;
    addr_d    = ss_addr;
    dat_d     = ss_dat;
    up_dat_d  = up_dat;
    upv_d     = up_valid;
    we_d      = ss_we;
    act_d     = ss_act;
    busy_d    = busy;
    done_d    = 1'b0;
    // abort outranks any handshake completing in the same cycle
    if (cmd_abort && state != IDLE && state != ABORT) begin
      state_d = ABORT;
      we_d    = 1'b0;
      upv_d   = 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_start) begin
          state_d   = SETUP;
          restore_d = cmd_restore;
          addr_d    = A_FIRST;
          act_d     = 1'b1;
          busy_d    = 1'b1;
        end
        SETUP: begin
          cnt_d   = LAT;
          state_d = restore ? DNWAIT : RDWAIT;
        end
        RDWAIT: if (cnt == '0) begin
          up_dat_d = ss_rdat;
          upv_d    = 1'b1;
          state_d  = UP;
        end else cnt_d = cnt - 3'd1;
        UP: if (up_ready) begin
          upv_d   = 1'b0;
          state_d = NEXT;
        end
        DNWAIT: if (dn_valid) begin
          dat_d   = dn_dat;
          state_d = WEARM;
        end
        WEARM: if (m2_fall) begin
          we_d    = 1'b1;
          state_d = WEHOLD;
        end
        WEHOLD: if (m2_fall) begin
          we_d    = 1'b0;
          state_d = NEXT;
        end
        NEXT: if (ss_addr == A_LAST) state_d = FIN;
        else begin
          addr_d  = ss_addr + 8'd1;
          state_d = SETUP;
        end
        FIN, ABORT: begin
          act_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mapper_ss_seq.sv
// tb_mapper_ss_seq: directed save/restore/abort/reset scenarios against a small mapper model.
module tb_mapper_ss_seq;
  logic clk = 0, rst = 1, m2 = 0;
  logic cmd_start = 0, cmd_restore = 0, cmd_abort = 0;
  logic up_ready = 0, dn_valid = 0;
  logic [7:0] dn_dat = 0;
  logic [7:0] ss_rdat, ss_addr, ss_dat, up_dat;
  logic busy, done, ss_act, ss_we, up_valid, dn_ready;
  int n_chk = 0, n_fail = 0;

  logic [7:0] rd_mem [0:255];
  assign ss_rdat = rd_mem[ss_addr];

  mapper_ss_seq #(.FIRST(0), .LAST(6), .RD_LAT(2)) dut (
    .clk(clk), .rst(rst), .m2(m2), .cmd_start(cmd_start), .cmd_restore(cmd_restore),
    .cmd_abort(cmd_abort), .busy(busy), .done(done), .ss_act(ss_act), .ss_we(ss_we),
    .ss_addr(ss_addr), .ss_dat(ss_dat), .ss_rdat(ss_rdat), .up_dat(up_dat),
    .up_valid(up_valid), .up_ready(up_ready), .dn_dat(dn_dat), .dn_valid(dn_valid),
    .dn_ready(dn_ready)
  );

  always #5 clk = ~clk;
  always #35 m2 = ~m2;

  logic [7:0] up_q[$], up_aq[$], wr_aq[$], wr_dq[$];
  int up_viol = 0, we_viol = 0, span_viol = 0, we_cyc = 0, done_cnt = 0, dn_mon_hs = 0;
  int w_total = 0, w_rise = 0;
  logic pstall = 0, pwe = 0;
  logic [7:0] pdat = 0, pa = 0, pd = 0;

  // mapper latches snapshot writes on falling m2
  always @(negedge m2) begin
    if (ss_act && ss_we) begin
      wr_aq.push_back(ss_addr);
      wr_dq.push_back(ss_dat);
      w_total <= w_total + 1;
    end
  end

  always @(posedge clk) begin
    if (up_valid && up_ready) begin
      up_q.push_back(up_dat);
      up_aq.push_back(ss_addr);
    end
    if (pstall && (!up_valid || up_dat != pdat)) up_viol <= up_viol + 1;
    pstall <= up_valid && !up_ready;
    pdat <= up_dat;
    if (pwe && ss_we && (ss_addr != pa || ss_dat != pd)) we_viol <= we_viol + 1;
    if (!pwe && ss_we) w_rise <= w_total;
    if (pwe && !ss_we && w_total == w_rise) span_viol <= span_viol + 1;
    pwe <= ss_we;
    pa <= ss_addr;
    pd <= ss_dat;
    if (ss_we) we_cyc <= we_cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
    if (dn_valid && dn_ready) dn_mon_hs <= dn_mon_hs + 1;
  end

  task automatic start_op(input logic rest);
    @(negedge clk);
    cmd_start = 1;
    cmd_restore = rest;
    @(negedge clk);
    cmd_start = 0;
    cmd_restore = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if ({busy, done, ss_act, ss_we, up_valid, dn_ready} !== 6'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000000", {busy, done, ss_act, ss_we, up_valid, dn_ready}); end
    n_chk++; if ({ss_addr, ss_dat, up_dat} !== 24'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 000000", {ss_addr, ss_dat, up_dat}); end
    rst = 0;
    @(negedge clk);
    n_chk++; if ({busy, ss_act, dn_ready} !== 3'b0) begin n_fail++; $display("FAIL idle_after_reset: got %b expected 000", {busy, ss_act, dn_ready}); end
  endtask

  task automatic test_save(input int per, input bit poke, input string tag);
    int q0, d0, w0, v0, cyc, low;
    bit got;
    q0 = up_q.size(); d0 = done_cnt; w0 = we_cyc; v0 = up_viol; cyc = 0; low = 0; got = 0;
    start_op(0);
    n_chk++; if ({ss_act, busy, ss_addr} !== {2'b11, 8'h00}) begin n_fail++; $display("FAIL %s_start: got act/busy/addr %b%b/%h expected 11/00", tag, ss_act, busy, ss_addr); end
    while (!got && cyc < 1000) begin
      if (done) got = 1; else if (!busy) low++;
      up_ready = (cyc % per) == 0;
      cmd_start = poke && cyc == 15;
      cmd_restore = poke;
      @(negedge clk); cyc++;
    end
    up_ready = 0; cmd_start = 0; cmd_restore = 0;
    @(negedge clk);
    n_chk++; if (!got) begin n_fail++; $display("FAIL %s_done_timeout: got no done expected done within 1000 cycles", tag); end
    n_chk++; if (low != 0) begin n_fail++; $display("FAIL %s_busy: got %0d busy-low cycles expected 0", tag, low); end
    n_chk++; if (up_q.size() - q0 != 7) begin n_fail++; $display("FAIL %s_count: got %0d bytes expected 7", tag, up_q.size() - q0); end
    for (int i = 0; i < 7; i++) begin
      n_chk++; if (up_q[q0+i] !== 8'(i + 1) || up_aq[q0+i] !== 8'(i)) begin n_fail++; $display("FAIL %s_byte%0d: got %h@%h expected %h@%h", tag, i, up_q[q0+i], up_aq[q0+i], 8'(i + 1), 8'(i)); end
    end
    n_chk++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt - d0); end
    n_chk++; if (we_cyc != w0) begin n_fail++; $display("FAIL %s_we: got %0d write cycles expected 0", tag, we_cyc - w0); end
    n_chk++; if (up_viol != v0) begin n_fail++; $display("FAIL %s_up_stable: got %0d violations expected 0", tag, up_viol - v0); end
    n_chk++; if ({done, busy, ss_act} !== 3'b0) begin n_fail++; $display("FAIL %s_end: got %b expected 000", tag, {done, busy, ss_act}); end
  endtask

  task automatic test_restore(input int gap, input string tag);
    int w0, d0, h0, s0, v0, idx, g, hs, cyc, late;
    bit got, phs;
    w0 = wr_aq.size(); d0 = done_cnt; h0 = dn_mon_hs; s0 = span_viol; v0 = we_viol;
    idx = 0; g = 0; hs = 0; cyc = 0; late = 0; got = 0; phs = 0;
    start_op(1);
    while (!got && cyc < 3000) begin
      if (phs && dn_ready) late++;
      if (done) got = 1;
      dn_valid = idx < 7 && g == 0;
      dn_dat = 8'h11 + 8'(idx);
      if (g > 0) g--;
      phs = dn_valid && dn_ready;
      if (phs) begin idx++; hs++; g = gap; end
      @(negedge clk); cyc++;
    end
    dn_valid = 0;
    @(negedge clk);
    n_chk++; if (!got) begin n_fail++; $display("FAIL %s_done_timeout: got no done expected done within 3000 cycles", tag); end
    n_chk++; if (hs != 7 || dn_mon_hs - h0 != 7) begin n_fail++; $display("FAIL %s_dn_hs: got %0d/%0d expected 7/7", tag, hs, dn_mon_hs - h0); end
    n_chk++; if (wr_aq.size() - w0 != 7) begin n_fail++; $display("FAIL %s_writes: got %0d expected 7", tag, wr_aq.size() - w0); end
    for (int i = 0; i < 7; i++) begin
      n_chk++; if (wr_dq[w0+i] !== 8'h11 + 8'(i) || wr_aq[w0+i] !== 8'(i)) begin n_fail++; $display("FAIL %s_write%0d: got %h@%h expected %h@%h", tag, i, wr_dq[w0+i], wr_aq[w0+i], 8'h11 + 8'(i), 8'(i)); end
    end
    n_chk++; if (span_viol != s0) begin n_fail++; $display("FAIL %s_we_span: got %0d pulses without m2 fall expected 0", tag, span_viol - s0); end
    n_chk++; if (we_viol != v0) begin n_fail++; $display("FAIL %s_we_stable: got %0d violations expected 0", tag, we_viol - v0); end
    n_chk++; if (late != 0) begin n_fail++; $display("FAIL %s_dn_ready: got %0d cycles high after handshake expected 0", tag, late); end
    n_chk++; if (done_cnt - d0 != 1 || {busy, dn_ready, ss_we} !== 3'b0) begin n_fail++; $display("FAIL %s_end: got done %0d busy/rdy/we %b expected 1/000", tag, done_cnt - d0, {busy, dn_ready, ss_we}); end
  endtask

  task automatic test_abort;
    int cyc, idx, q0;
    bit got;
    cyc = 0; idx = 0; got = 0;
    start_op(1);
    while (!(ss_we === 1'b1 && ss_addr === 8'd3) && cyc < 3000) begin
      dn_valid = idx < 7;
      dn_dat = 8'h21 + 8'(idx);
      if (dn_valid && dn_ready) idx++;
      @(negedge clk); cyc++;
    end
    dn_valid = 0;
    n_chk++; if (cyc >= 3000) begin n_fail++; $display("FAIL abort_reach: got no WEHOLD at addr 3 expected within 3000 cycles"); end
    cmd_abort = 1;
    @(negedge clk);
    cmd_abort = 0;
    n_chk++; if ({ss_we, dn_ready, up_valid, busy, done} !== 5'b00010) begin n_fail++; $display("FAIL abort_state: got we/rdy/upv/busy/done %b expected 00010", {ss_we, dn_ready, up_valid, busy, done}); end
    @(negedge clk);
    n_chk++; if ({done, busy, ss_act} !== 3'b100) begin n_fail++; $display("FAIL abort_done: got done/busy/act %b expected 100", {done, busy, ss_act}); end
    q0 = up_q.size();
    cmd_start = 1; cmd_restore = 0;
    @(negedge clk);
    cmd_start = 0;
    n_chk++; if ({ss_addr, busy, done} !== {8'h00, 2'b10}) begin n_fail++; $display("FAIL abort_restart: got addr/busy/done %h/%b expected 00/10", ss_addr, {busy, done}); end
    cyc = 0; up_ready = 1;
    while (!got && cyc < 1000) begin
      if (done) got = 1;
      @(negedge clk); cyc++;
    end
    up_ready = 0;
    n_chk++; if (!got || up_q.size() - q0 != 7 || up_q[q0] !== 8'h01) begin n_fail++; $display("FAIL abort_resave: got done %0d count %0d first %h expected 1 7 01", got, up_q.size() - q0, up_q[q0]); end
  endtask

  task automatic test_async_reset;
    int cyc, d0;
    cyc = 0; up_ready = 0;
    start_op(0);
    while (up_valid !== 1'b1 && cyc < 50) begin @(negedge clk); cyc++; end
    n_chk++; if (up_valid !== 1'b1) begin n_fail++; $display("FAIL areset_reach: got up_valid %b expected 1", up_valid); end
    d0 = done_cnt;
    #2 rst = 1;
    #1;
    n_chk++; if ({busy, done, ss_act, ss_we, up_valid, dn_ready} !== 6'b0) begin n_fail++; $display("FAIL areset_ctrl: got %b expected 000000", {busy, done, ss_act, ss_we, up_valid, dn_ready}); end
    n_chk++; if ({ss_addr, ss_dat, up_dat} !== 24'h0) begin n_fail++; $display("FAIL areset_data: got %h expected 000000", {ss_addr, ss_dat, up_dat}); end
    @(negedge clk); @(negedge clk);
    rst = 0;
    @(negedge clk); @(negedge clk);
    n_chk++; if (done_cnt != d0 || busy !== 1'b0) begin n_fail++; $display("FAIL areset_nodone: got done %0d busy %b expected 0 0", done_cnt - d0, busy); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rd_mem[i] = 8'hEE;
    for (int i = 0; i < 7; i++) rd_mem[i] = 8'(i + 1);
    test_reset;
    test_save(1, 0, "save");
    test_save(3, 1, "save_stall");
    test_restore(0, "restore");
    test_restore(10, "restore_gap");
    test_abort;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
